unidade_load_store: RTL and testbench

- Initiator side of the data-memory interface of the 8-bit nRisc core.
- Accepts load/store requests from the CPU datapath through a valid/ready handshake.
- Queues stores in a small in-order write buffer.
- Drives the memory's address, write-data and EscMem/LerMem strobes, then returns load data with a one-cycle response pulse.
- Memory timing contract: the memory writes on the rising edge while EscMem is high, and reads on the falling edge while LerMem is high.

---
 rtl/unidade_load_store_if.sv | 32 +++
 rtl/unidade_load_store.sv | 183 ++++++++++++++++++
 tb/tb_unidade_load_store.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_load_store_if.sv
// unidade_load_store_if: CPU request channel plus data-memory port of the
// nRisc load/store unit. "master" is the unit itself (memory initiator);
// "slave" is the surrounding CPU datapath and data memory.
interface unidade_load_store_if #(
  parameter int LARG_DADO = 8,
  parameter int LARG_END  = 8
);
  logic                 Req;
  logic                 Esc;
  logic [LARG_END-1:0]  Endereco;
  logic [LARG_DADO-1:0] DadoEscrito;
  logic                 Pronto;
  logic                 RspValido;
  logic [LARG_DADO-1:0] RspDado;
  logic [LARG_END-1:0]  MemEndereco;
  logic [LARG_DADO-1:0] MemDadoEscrito;
  logic                 MemEscMem;
  logic                 MemLerMem;
  logic [LARG_DADO-1:0] MemDadoLido;

  modport master (
    input  Req, Esc, Endereco, DadoEscrito, MemDadoLido,
    output Pronto, RspValido, RspDado,
    output MemEndereco, MemDadoEscrito, MemEscMem, MemLerMem
  );

  modport slave (
    output Req, Esc, Endereco, DadoEscrito, MemDadoLido,
    input  Pronto, RspValido, RspDado,
    input  MemEndereco, MemDadoEscrito, MemEscMem, MemLerMem
  );
endinterface

// File: rtl/unidade_load_store.sv
// unidade_load_store: load/store initiator for the nRisc data memory.
// Stores go through an in-order circular write buffer drained one per cycle;
// loads wait for the drain so program order is kept.
// Build macro STORE_FWD_EN: loads hitting the buffer are answered from the
// youngest matching entry; missing loads issue ahead of the pending drain.
module unidade_load_store #(
  parameter int LARG_DADO = 8,
  parameter int LARG_END  = 8,
  parameter int PROF_BUF  = 4
) (
  input logic Clock,
  input logic Reset,
  unidade_load_store_if.master bus
);
  localparam int unsigned PW = (PROF_BUF > 1) ? $clog2(PROF_BUF) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ESCREVE = 2'd1;
  localparam logic [1:0] LE      = 2'd2;

  logic [1:0]           estado;
  logic [LARG_END-1:0]  fila_end  [PROF_BUF];
  logic [LARG_DADO-1:0] fila_dado [PROF_BUF];
  logic [PW-1:0]        head, tail, head_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 pend_load;
  logic [LARG_END-1:0]  ld_end;
  logic                 cheio, vazio, aceita, push, pop, ld_aceita;
  logic                 ld_ok, ld_prio;
  logic [LARG_END-1:0]  prox_end;
  logic [LARG_DADO-1:0] prox_dado;
  logic                 rsp_valido;
  logic [LARG_DADO-1:0] rsp_dado;
  logic [LARG_END-1:0]  mem_end;
  logic [LARG_DADO-1:0] mem_dado;
  logic                 mem_esc, mem_ler;

  assign cheio     = (cnt == CW'(PROF_BUF));
  assign vazio     = (cnt == '0);
  assign aceita    = bus.Req && !cheio && !pend_load;
  assign push      = aceita && bus.Esc;
  assign ld_aceita = aceita && !bus.Esc;
  assign pop       = (estado == ESCREVE);
  assign cnt_nx    = cnt + CW'(push) - CW'(pop);
  assign head_nx   = head + PW'(1);

  assign bus.Pronto         = !cheio && !pend_load;
  assign bus.RspValido      = rsp_valido;
  assign bus.RspDado        = rsp_dado;
  assign bus.MemEndereco    = mem_end;
  assign bus.MemDadoEscrito = mem_dado;
  assign bus.MemEscMem      = mem_esc;
  assign bus.MemLerMem      = mem_ler;

  // Entry to present after the head is popped; with one entry left and a
  // push on the same edge, that entry is the incoming store, not yet in the array.
  always_comb begin
    if (push && cnt == CW'(1)) begin
      prox_end  = bus.Endereco;
      prox_dado = bus.DadoEscrito;
    end else begin
      prox_end  = fila_end[head_nx];
      prox_dado = fila_dado[head_nx];
    end
  end

`ifdef STORE_FWD_EN
  logic                 fwd_match;
  logic [LARG_DADO-1:0] fwd_dado;
  logic [PW-1:0]        fwd_idx;
  logic                 fwd_pend;
  logic [LARG_DADO-1:0] fwd_dado_r;

  // Oldest-to-youngest scan of the valid entries; the last hit wins.
  always_comb begin
    fwd_match = 1'b0;
    fwd_dado  = '0;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < PROF_BUF; i++) begin
      fwd_idx = head + PW'(i);
      if (CW'(i) < cnt && fila_end[fwd_idx] == bus.Endereco) begin
        fwd_match = 1'b1;
        fwd_dado  = fila_dado[fwd_idx];
      end
    end
  end

  assign ld_ok   = pend_load && !fwd_pend;
  assign ld_prio = ld_ok || (ld_aceita && !fwd_match);
`else
  assign ld_ok   = pend_load && vazio;
  assign ld_prio = 1'b0;
`endif

  // Buffer storage: written at the tail on every accepted store.
  always_ff @(posedge Clock) begin
    if (push) begin
      fila_end[tail]  <= bus.Endereco;
      fila_dado[tail] <= bus.DadoEscrito;
    end
  end

  // Pointers, pending load, FSM and registered memory/response outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado     <= OCIOSO;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      pend_load  <= 1'b0;
      ld_end     <= '0;
      rsp_valido <= 1'b0;
      rsp_dado   <= '0;
      mem_end    <= '0;
      mem_dado   <= '0;
      mem_esc    <= 1'b0;
      mem_ler    <= 1'b0;
`ifdef STORE_FWD_EN
      fwd_pend   <= 1'b0;
      fwd_dado_r <= '0;
`endif
    end else begin
      rsp_valido <= 1'b0;
      cnt        <= cnt_nx;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head_nx;
      if (ld_aceita) begin
        ld_end    <= bus.Endereco;
        pend_load <= 1'b1;
      end
`ifdef STORE_FWD_EN
      if (ld_aceita) begin
        fwd_pend   <= fwd_match;
        fwd_dado_r <= fwd_dado;
      end
      if (fwd_pend) begin
        rsp_valido <= 1'b1;
        rsp_dado   <= fwd_dado_r;
        pend_load  <= 1'b0;
        fwd_pend   <= 1'b0;
      end
`endif
      case (estado)
        OCIOSO: begin
          if (ld_ok) begin
            estado  <= LE;
            mem_ler <= 1'b1;
            mem_end <= ld_end;
          end else if (!vazio) begin
            estado   <= ESCREVE;
            mem_esc  <= 1'b1;
            mem_end  <= fila_end[head];
            mem_dado <= fila_dado[head];
          end
        end
        ESCREVE: begin
          if (cnt_nx != '0 && !ld_prio) begin
            mem_end  <= prox_end;
            mem_dado <= prox_dado;
          end else begin
            estado   <= OCIOSO;
            mem_esc  <= 1'b0;
            mem_dado <= '0;
          end
        end
        LE: begin
          rsp_valido <= 1'b1;
          rsp_dado   <= bus.MemDadoLido;
          pend_load  <= 1'b0;
          mem_ler    <= 1'b0;
          estado     <= OCIOSO;
        end
        default: begin
          estado   <= OCIOSO;
          mem_esc  <= 1'b0;
          mem_ler  <= 1'b0;
          mem_dado <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unidade_load_store.sv
// tb_unidade_load_store: scoreboard bench for unidade_load_store with a
// behavioural data memory (writes on rising edge, reads on falling edge).
module tb_unidade_load_store;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  unidade_load_store_if #(.LARG_DADO(8), .LARG_END(8)) bus ();

  unidade_load_store #(.LARG_DADO(8), .LARG_END(8), .PROF_BUF(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned rsp_cnt = 0;
  int unsigned ler_cnt = 0;
  int unsigned last_rsp_cyc = 0;
  int unsigned last_ler_cyc = 0;
  int unsigned stalls = 0;
  int unsigned wr_cyc_of [256];
  int unsigned wr_cycs [$];
  wr_t         wq [$];
  logic [7:0]  rq [$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  mem [256];
  logic        mem_init = 1'b0;
  logic [7:0]  rd_q = 8'h00;
  wr_t         mon_w;
  logic [7:0]  mon_r;

  function automatic logic [7:0] init_val(input int unsigned i);
    logic [7:0] v;
    v = 8'(i) ^ 8'h5A;
    if (i == 32'h20) v = 8'h5C;
    if (i == 32'h05) v = 8'h77;
    return v;
  endfunction

  // Data memory model
  assign bus.MemDadoLido = rd_q;
  always @(posedge Clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (bus.MemEscMem) begin
      mem[bus.MemEndereco] <= bus.MemDadoEscrito;
    end
  end
  always @(negedge Clock) if (bus.MemLerMem) rd_q <= mem[bus.MemEndereco];

  always @(posedge Clock) cyc <= cyc + 1;

  // Output monitor: compares memory writes and load responses to the queues
  always @(negedge Clock) begin
    if (Reset) begin
      vectors++;
      if (bus.MemEscMem && bus.MemLerMem) begin
        miscompares++;
        $display("FAIL strobe_excl: EscMem=1 LerMem=1 at cycle %0d, required not both", cyc);
      end
      if (!bus.MemEscMem) begin
        vectors++;
        if (bus.MemDadoEscrito !== 8'h00) begin
          miscompares++;
          $display("FAIL wdata_idle: MemDadoEscrito=%h, required 00", bus.MemDadoEscrito);
        end
      end else begin
        wr_cycs.push_back(cyc);
        wr_cyc_of[bus.MemEndereco] = cyc;
        vectors++;
        if (wq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: A=%h D=%h, required no write", bus.MemEndereco, bus.MemDadoEscrito);
        end else begin
          mon_w = wq.pop_front();
          if (bus.MemEndereco !== mon_w.a || bus.MemDadoEscrito !== mon_w.d) begin
            miscompares++;
            $display("FAIL write: A=%h D=%h, required A=%h D=%h", bus.MemEndereco, bus.MemDadoEscrito, mon_w.a, mon_w.d);
          end
        end
      end
      if (bus.MemLerMem) begin
        ler_cnt++;
        last_ler_cyc = cyc;
      end
      if (bus.RspValido) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        vectors++;
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: RspDado=%h, required no response", bus.RspDado);
        end else begin
          mon_r = rq.pop_front();
          if (bus.RspDado !== mon_r) begin
            miscompares++;
            $display("FAIL rsp_data: RspDado=%h, required %h", bus.RspDado, mon_r);
          end
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Presents a request (Req left high) and returns after the accept edge.
  task automatic issue(input logic esc, input logic [7:0] a, input logic [7:0] d,
                       input bit sb, output int unsigned acc);
    int unsigned n;
    wr_t e;
    n = 0;
    bus.Req = 1'b1;
    bus.Esc = esc;
    bus.Endereco = a;
    bus.DadoEscrito = d;
    while (bus.Pronto !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    stalls += n;
    if (bus.Pronto !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: Pronto=%b after %0d cycles, required 1", bus.Pronto, n);
      bus.Req = 1'b0;
      acc = cyc;
    end else begin
      step(1);
      acc = cyc;
      if (sb) begin
        if (esc) begin
          e.a = a;
          e.d = d;
          wq.push_back(e);
          ref_mem[a] = d;
        end else begin
          rq.push_back(ref_mem[a]);
        end
      end
    end
  endtask

  task automatic wait_rsp(input int unsigned target, input string nm);
    int unsigned k;
    k = 0;
    while (rsp_cnt < target && k < 30) begin
      @(negedge Clock);
      #1;
      k++;
    end
    if (rsp_cnt < target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: responses=%0d, required %0d", nm, rsp_cnt, target);
    end
  endtask

  task automatic test_reset();
    int unsigned acc, n0;
    step(3);
    vectors++;
    if ({bus.MemEscMem, bus.MemLerMem, bus.RspValido, bus.RspDado, bus.MemEndereco, bus.MemDadoEscrito} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: Esc=%b Ler=%b Rsp=%b RD=%h A=%h WD=%h, required all 0",
               bus.MemEscMem, bus.MemLerMem, bus.RspValido, bus.RspDado, bus.MemEndereco, bus.MemDadoEscrito);
    end
    @(negedge Clock);
    Reset = 1'b1;
    step(1);
    issue(1'b1, 8'h05, 8'h12, 1'b0, acc);
    bus.Req = 1'b0;
    step(1);
    vectors++;
    if (bus.MemEscMem !== 1'b1 || bus.MemEndereco !== 8'h05 || bus.MemDadoEscrito !== 8'h12) begin
      miscompares++;
      $display("FAIL escreve_start: Esc=%b A=%h D=%h, required 1 05 12", bus.MemEscMem, bus.MemEndereco, bus.MemDadoEscrito);
    end
    #1 Reset = 1'b0;
    #1;
    vectors++;
    if (bus.MemEscMem !== 1'b0 || bus.MemLerMem !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: Esc=%b Ler=%b, required 0 0", bus.MemEscMem, bus.MemLerMem);
    end
    step(1);
    @(negedge Clock);
    Reset = 1'b1;
    step(1);
    vectors++;
    if (bus.Pronto !== 1'b1) begin
      miscompares++;
      $display("FAIL pronto_after_reset: Pronto=%b, required 1", bus.Pronto);
    end
    step(3);
    vectors++;
    if (mem[8'h05] !== 8'h77) begin
      miscompares++;
      $display("FAIL reset_mem: mem[05]=%h, required 77", mem[8'h05]);
    end
    n0 = rsp_cnt;
    issue(1'b0, 8'h05, 8'h00, 1'b1, acc);
    bus.Req = 1'b0;
    wait_rsp(n0 + 1, "reset_load");
    vectors++;
    if (last_rsp_cyc - acc !== 2) begin
      miscompares++;
      $display("FAIL reset_load_latency: %0d cycles, required 2 (buffer empty)", last_rsp_cyc - acc);
    end
    step(4);
  endtask

  task automatic test_load_empty();
    int unsigned acc, n0;
    n0 = rsp_cnt;
    issue(1'b0, 8'h20, 8'h00, 1'b1, acc);
    bus.Req = 1'b0;
    vectors++;
    if (bus.Pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL load_t0_pronto: Pronto=%b, required 0", bus.Pronto);
    end
    step(1);
    vectors++;
    if (bus.MemLerMem !== 1'b1 || bus.MemEndereco !== 8'h20 || bus.Pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL load_t1: Ler=%b A=%h Pronto=%b, required 1 20 0", bus.MemLerMem, bus.MemEndereco, bus.Pronto);
    end
    step(1);
    vectors++;
    if (bus.RspValido !== 1'b1 || bus.RspDado !== 8'h5C || bus.Pronto !== 1'b1 || bus.MemLerMem !== 1'b0) begin
      miscompares++;
      $display("FAIL load_t2: Rsp=%b RD=%h Pronto=%b Ler=%b, required 1 5c 1 0",
               bus.RspValido, bus.RspDado, bus.Pronto, bus.MemLerMem);
    end
    wait_rsp(n0 + 1, "load_empty");
    step(4);
  endtask

  task automatic test_store_load();
    int unsigned acc, n0, exp_lat;
`ifdef STORE_FWD_EN
    exp_lat = 1;
`else
    exp_lat = 3;
`endif
    n0 = rsp_cnt;
    issue(1'b1, 8'h10, 8'hAB, 1'b1, acc);
    issue(1'b0, 8'h10, 8'h00, 1'b1, acc);
    bus.Req = 1'b0;
    wait_rsp(n0 + 1, "store_load");
    vectors++;
    if (last_rsp_cyc - acc !== exp_lat) begin
      miscompares++;
      $display("FAIL store_load_latency: %0d cycles, required %0d", last_rsp_cyc - acc, exp_lat);
    end
    step(6);
  endtask

  task automatic test_back_to_back();
    int unsigned acc, s0;
    wr_cycs.delete();
    s0 = stalls;
    for (int i = 0; i < 5; i++) issue(1'b1, 8'h60 + 8'(i), 8'hC0 + 8'(i), 1'b1, acc);
    bus.Req = 1'b0;
    step(10);
    vectors++;
    if (stalls - s0 !== 0) begin
      miscompares++;
      $display("FAIL b2b_backpressure: %0d stall cycles, required 0 (count never reaches 4)", stalls - s0);
    end
    vectors++;
    if (wr_cycs.size() !== 5) begin
      miscompares++;
      $display("FAIL b2b_write_count: %0d writes, required 5", wr_cycs.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        vectors++;
        if (wr_cycs[i] !== wr_cycs[0] + i) begin
          miscompares++;
          $display("FAIL b2b_consecutive: write %0d at cycle %0d, required %0d", i, wr_cycs[i], wr_cycs[0] + i);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned acc, n0;
    n0 = rsp_cnt;
    issue(1'b1, 8'hFF, 8'hA5, 1'b1, acc);
    bus.Req = 1'b0;
    step(1);
    issue(1'b1, 8'h00, 8'h3C, 1'b1, acc);
    issue(1'b0, 8'hFF, 8'h00, 1'b1, acc);
    issue(1'b0, 8'h00, 8'h00, 1'b1, acc);
    bus.Req = 1'b0;
    wait_rsp(n0 + 2, "wrap");
    step(6);
    vectors++;
    if (mem[8'hFF] !== 8'hA5 || mem[8'h00] !== 8'h3C) begin
      miscompares++;
      $display("FAIL wrap_mem: mem[ff]=%h mem[00]=%h, required a5 3c", mem[8'hFF], mem[8'h00]);
    end
  endtask

  task automatic test_fwd();
    int unsigned acc, n0, l0, exp_lat, exp_ler;
`ifdef STORE_FWD_EN
    exp_lat = 1;
    exp_ler = 0;
`else
    exp_lat = 3;
    exp_ler = 1;
`endif
    n0 = rsp_cnt;
    l0 = ler_cnt;
    issue(1'b1, 8'h30, 8'h11, 1'b1, acc);
    issue(1'b1, 8'h30, 8'h22, 1'b1, acc);
    issue(1'b0, 8'h30, 8'h00, 1'b1, acc);
    bus.Req = 1'b0;
    wait_rsp(n0 + 1, "fwd_hit");
    vectors++;
    if (last_rsp_cyc - acc !== exp_lat) begin
      miscompares++;
      $display("FAIL fwd_hit_latency: %0d cycles, required %0d", last_rsp_cyc - acc, exp_lat);
    end
    step(6);
    vectors++;
    if (ler_cnt - l0 !== exp_ler) begin
      miscompares++;
      $display("FAIL fwd_hit_reads: %0d read cycles, required %0d", ler_cnt - l0, exp_ler);
    end
    n0 = rsp_cnt;
    issue(1'b1, 8'h50, 8'h01, 1'b1, acc);
    issue(1'b1, 8'h51, 8'h02, 1'b1, acc);
    issue(1'b0, 8'h40, 8'h00, 1'b1, acc);
    bus.Req = 1'b0;
    wait_rsp(n0 + 1, "fwd_miss");
    step(8);
    vectors++;
`ifdef STORE_FWD_EN
    if (!(last_ler_cyc < wr_cyc_of[8'h51])) begin
      miscompares++;
      $display("FAIL fwd_miss_order: read at %0d write(51) at %0d, required read first", last_ler_cyc, wr_cyc_of[8'h51]);
    end
`else
    if (!(last_ler_cyc > wr_cyc_of[8'h51])) begin
      miscompares++;
      $display("FAIL drain_order: read at %0d write(51) at %0d, required write first", last_ler_cyc, wr_cyc_of[8'h51]);
    end
`endif
  endtask

  task automatic test_final();
    vectors++;
    if (wq.size() !== 0 || rq.size() !== 0) begin
      miscompares++;
      $display("FAIL leftover: writes=%0d responses=%0d outstanding, required 0 0", wq.size(), rq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = init_val(i);
      wr_cyc_of[i] = 0;
    end
    bus.Req = 1'b0;
    bus.Esc = 1'b0;
    bus.Endereco = 8'h00;
    bus.DadoEscrito = 8'h00;
    test_reset();
    test_load_empty();
    test_store_load();
    test_back_to_back();
    test_wrap();
    test_fwd();
    test_final();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
